// File: rtl/modos_nivel_multi.sv
// N-channel need-level trackers: a shared seconds prescaler drives per-channel decay and hold-to-raise FSMs.
// Build option: define ALARMA_MULTI_EN to drive alarma when two or more channels are critical.
module modos_nivel_multi #(
  parameter int N_CH     = 4,
  parameter int LVL_W    = 2,
  parameter int TICK_DIV = 50000000,
  parameter int TEST_DIV = 5000000,
  parameter int DECAY_S  = 10,
  parameter int HOLD_S   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   test,
  input  logic [N_CH-1:0]        entrada,
  input  logic [N_CH-1:0]        activo,
  output logic [N_CH*LVL_W-1:0]  nivel,
  output logic [N_CH-1:0]        senal_hold,
  output logic [N_CH-1:0]        critico,
  output logic                   tick_seg,
  output logic                   alarma
);

  localparam int MAX_DIV = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
  localparam int PW = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam int DW = (DECAY_S > 1) ? $clog2(DECAY_S) : 1;
  localparam int HW = (HOLD_S > 1) ? $clog2(HOLD_S) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] TEST_LAST = PW'(TEST_DIV - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_S - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_S - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = '1;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} st_t;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_last;
  logic          test_q;
  logic          test_chg;

  // A mode switch restarts the count so no stale partial period is ever credited.
  assign test_chg = test ^ test_q;
  assign pre_last = test ? TEST_LAST : TICK_LAST;
  assign tick_seg = (pre_q == pre_last) && !test_chg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      test_q <= 1'b0;
    end else begin
      test_q <= test;
      if (test_chg || tick_seg) pre_q <= '0;
      else                      pre_q <= pre_q + PW'(1);
    end
  end

  logic [N_CH-1:0] crit_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    st_t              st_q, st_d;
    logic [DW-1:0]    dec_q, dec_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             pulse_d;
    logic             req;
    logic             do_decay;

    assign req = entrada[i] & activo[i];
    // Entering HOLD beats a coincident decay tick; HOLD itself never decays.
    assign do_decay = tick_seg && (((st_q == IDLE) && !req) || (st_q == DONE));

    always_comb begin
      st_d    = st_q;
      dec_d   = dec_q;
      hold_d  = hold_q;
      lvl_d   = lvl_q;
      pulse_d = 1'b0;
      if (do_decay) begin
        if (dec_q == DECAY_LAST) begin
          dec_d = '0;
          if (lvl_q != '0) lvl_d = lvl_q - LVL_W'(1);
        end else begin
          dec_d = dec_q + DW'(1);
        end
      end
      case (st_q)
        IDLE: begin
          if (req) begin
            st_d   = HOLD;
            hold_d = '0;
          end
        end
        HOLD: begin
          // Completion wins even if the request drops on the same tick.
          if (tick_seg && (hold_q == HOLD_LAST)) begin
            if (lvl_q != LVL_MAX) lvl_d = lvl_q + LVL_W'(1);
            pulse_d = 1'b1;
            dec_d   = '0;
            hold_d  = '0;
            st_d    = DONE;
          end else if (!req) begin
            hold_d = '0;
            st_d   = IDLE;
          end else if (tick_seg) begin
            hold_d = hold_q + HW'(1);
          end
        end
        DONE: begin
          if (!entrada[i]) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end

    assign crit_d[i] = (lvl_d == '0);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q          <= IDLE;
        dec_q         <= '0;
        hold_q        <= '0;
        lvl_q         <= LVL_MAX;
        senal_hold[i] <= 1'b0;
        critico[i]    <= 1'b0;
      end else begin
        st_q          <= st_d;
        dec_q         <= dec_d;
        hold_q        <= hold_d;
        lvl_q         <= lvl_d;
        senal_hold[i] <= pulse_d;
        critico[i]    <= crit_d[i];
      end
    end

    assign nivel[i*LVL_W +: LVL_W] = lvl_q;
  end

`ifdef ALARMA_MULTI_EN
  localparam int CW = $clog2(N_CH + 1) + 1;
  logic [CW-1:0] n_crit;
  logic          alarma_q;

  // Counted from next-state criticals so alarma lines up with critico.
  always_comb begin
    n_crit = '0;
    for (int k = 0; k < N_CH; k++) n_crit = n_crit + CW'(crit_d[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alarma_q <= 1'b0;
    else        alarma_q <= (n_crit >= CW'(2));
  end

  assign alarma = alarma_q;
`else
  assign alarma = 1'b0;
`endif

endmodule

// File: tb/tb_modos_nivel_multi.sv
// Directed vector bench for modos_nivel_multi (4 channels, 2-bit levels, short dividers).
module tb_modos_nivel_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       test;
  logic [3:0] entrada;
  logic [3:0] activo;
  logic [7:0] nivel;
  logic [3:0] senal_hold;
  logic [3:0] critico;
  logic       tick_seg;
  logic       alarma;

  int errors = 0;
  int checks = 0;
  int pulse_total = 0;
  int base;

`ifdef ALARMA_MULTI_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  modos_nivel_multi #(
    .N_CH(4), .LVL_W(2), .TICK_DIV(10), .TEST_DIV(2), .DECAY_S(3), .HOLD_S(2)
  ) dut (
    .clk(clk), .reset(reset), .test(test), .entrada(entrada), .activo(activo),
    .nivel(nivel), .senal_hold(senal_hold), .critico(critico),
    .tick_seg(tick_seg), .alarma(alarma)
  );

  always #5 clk = ~clk;

  always @(negedge clk) pulse_total <= pulse_total + $countones(senal_hold);

  typedef struct {
    int         adv;
    logic [7:0] nivel;
    logic [3:0] crit;
    logic       tick;
  } vec_t;

  vec_t tbl [7];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic alm_exp(input logic [3:0] c);
    return ALM && ($countones(c) >= 2);
  endfunction

  task automatic do_reset();
    reset   = 1'b0;
    test    = 1'b0;
    entrada = 4'b0000;
    activo  = 4'b1111;
    step(2);
    chk("rst_nivel", 32'(nivel), 32'hFF);
    chk("rst_senal", 32'(senal_hold), 32'h0);
    chk("rst_crit", 32'(critico), 32'h0);
    chk("rst_tick", 32'(tick_seg), 32'h0);
    chk("rst_alarma", 32'(alarma), 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{29, 8'hFF, 4'h0, 1'b1};
    tbl[1] = '{1,  8'hAA, 4'h0, 1'b0};
    tbl[2] = '{29, 8'hAA, 4'h0, 1'b1};
    tbl[3] = '{1,  8'h55, 4'h0, 1'b0};
    tbl[4] = '{29, 8'h55, 4'h0, 1'b1};
    tbl[5] = '{1,  8'h00, 4'hF, 1'b0};
    tbl[6] = '{50, 8'h00, 4'hF, 1'b0};

    // Free-running decay from reset
    do_reset();
    base = pulse_total;
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].adv);
      chk($sformatf("decay_nivel[%0d]", i), 32'(nivel), 32'(tbl[i].nivel));
      chk($sformatf("decay_crit[%0d]", i), 32'(critico), 32'(tbl[i].crit));
      chk($sformatf("decay_tick[%0d]", i), 32'(tick_seg), 32'(tbl[i].tick));
      chk($sformatf("decay_alarma[%0d]", i), 32'(alarma), 32'(alm_exp(tbl[i].crit)));
    end
    chk("decay_no_pulse", 32'(pulse_total - base), 32'd0);

    // Hold on channel 0 from level 1, then release and re-press
    do_reset();
    step(60);
    chk("hold_start", 32'(nivel), 32'h55);
    entrada = 4'b0001;
    base = pulse_total;
    step(20);
    chk("hold_nivel", 32'(nivel), 32'h56);
    chk("hold_senal", 32'(senal_hold), 32'h1);
    step(1);
    chk("hold_senal_end", 32'(senal_hold), 32'h0);
    step(29);
    chk("hold_kept_nivel", 32'(nivel), 32'h01);
    chk("hold_kept_pulses", 32'(pulse_total - base), 32'd1);
    chk("hold_kept_crit", 32'(critico), 32'hE);
    entrada = 4'b0000;
    step(1);
    entrada = 4'b0001;
    step(19);
    chk("repress_nivel", 32'(nivel), 32'h02);
    chk("repress_senal", 32'(senal_hold), 32'h1);
    entrada = 4'b0000;

    // Same press with the channel disabled
    do_reset();
    step(60);
    entrada = 4'b0001;
    activo  = 4'b1110;
    base = pulse_total;
    step(20);
    chk("gated_nivel_e80", 32'(nivel), 32'h55);
    step(10);
    chk("gated_nivel_e90", 32'(nivel), 32'h00);
    chk("gated_pulses", 32'(pulse_total - base), 32'd0);
    entrada = 4'b0000;
    activo  = 4'b1111;

    // One-tick press on channel 1 delays its next decrement by one tick
    do_reset();
    base = pulse_total;
    step(5);
    entrada = 4'b0010;
    step(5);
    chk("short_e10", 32'(nivel), 32'hFF);
    entrada = 4'b0000;
    step(20);
    chk("short_e30", 32'(nivel), 32'hAE);
    step(10);
    chk("short_e40", 32'(nivel), 32'hAA);
    chk("short_pulses", 32'(pulse_total - base), 32'd0);

    // Test-mode prescaler and mode-switch suppression
    do_reset();
    step(3);
    test = 1'b1;
    step(1);
    chk("test_e4_tick", 32'(tick_seg), 32'h0);
    step(1);
    chk("test_e5_tick", 32'(tick_seg), 32'h1);
    step(1);
    chk("test_e6_tick", 32'(tick_seg), 32'h0);
    step(1);
    chk("test_e7_tick", 32'(tick_seg), 32'h1);
    test = 1'b0;
    #1;
    chk("switch_no_tick", 32'(tick_seg), 32'h0);
    step(1);
    chk("switch_cleared", 32'(tick_seg), 32'h0);
    step(8);
    chk("normal_e16_tick", 32'(tick_seg), 32'h0);
    step(1);
    chk("normal_e17_tick", 32'(tick_seg), 32'h1);

    // Reset asserted in the middle of a hold
    do_reset();
    step(60);
    entrada = 4'b0001;
    step(15);
    reset = 1'b0;
    #1;
    chk("midrst_nivel", 32'(nivel), 32'hFF);
    chk("midrst_senal", 32'(senal_hold), 32'h0);
    chk("midrst_crit", 32'(critico), 32'h0);
    entrada = 4'b0000;
    base = pulse_total;
    step(2);
    reset = 1'b1;
    step(20);
    chk("midrst_after_nivel", 32'(nivel), 32'hFF);
    chk("midrst_pulses", 32'(pulse_total - base), 32'd0);

    // Two channels critical, then one of them raised
    do_reset();
    step(60);
    entrada = 4'b1010;
    step(20);
    chk("alm_raise_senal", 32'(senal_hold), 32'hA);
    chk("alm_raise_nivel", 32'(nivel), 32'h99);
    entrada = 4'b0000;
    step(10);
    chk("alm_two_nivel", 32'(nivel), 32'h88);
    chk("alm_two_crit", 32'(critico), 32'h5);
    chk("alm_two_alarma", 32'(alarma), 32'(alm_exp(4'h5)));
    entrada = 4'b0100;
    step(20);
    chk("alm_one_nivel", 32'(nivel), 32'h54);
    chk("alm_one_senal", 32'(senal_hold), 32'h4);
    chk("alm_one_crit", 32'(critico), 32'h1);
    chk("alm_one_alarma", 32'(alarma), 32'(alm_exp(4'h1)));
    entrada = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modos_nivel_multi.md
Name: modos_nivel_multi

Overview:
- Parametrised N-channel successor of the four fixed 2-bit "need" level trackers (animo, descanso, energia, medicina).
- One shared seconds prescaler drives per-channel level counters.
- Each level decays over time; holding a debounced request input for a set number of seconds raises it by one.
- Adds a test-mode time acceleration, a critical-level flag and a per-channel gating enable.
- Sits between the debounce block and the LED/display/state-machine logic.

Parameters:
N_CH, 4, number of channels
LVL_W, 2, level width per channel; max level = 2^LVL_W-1
TICK_DIV, 50000000, clk cycles per second tick in normal mode
TEST_DIV, 5000000, clk cycles per tick when test=1
DECAY_S, 10, ticks between automatic decrements
HOLD_S, 5, consecutive ticks entrada must be held to earn an increment

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
test  in  1  selects TEST_DIV instead of TICK_DIV
entrada  in  N_CH  debounced request per channel, active-high, synchronous to clk
activo  in  N_CH  channel enable; 0 makes entrada ignored
nivel  out  N_CH*LVL_W  levels; channel i at bits [i*LVL_W +: LVL_W]
senal_hold  out  N_CH  one-cycle pulse when a hold completes
critico  out  N_CH  1 while the channel level == 0
tick_seg  out  1  one-cycle pulse per tick
alarma  out  1  multi-channel critical alarm (see Optional Feature)

Behaviour:
- Reset values (reset=0, asynchronous):
  - prescaler=0, tick_seg=0.
  - every nivel = max (all ones), senal_hold=0, critico=0, alarma=0.
  - all channels in IDLE with decay_cnt=0 and hold_cnt=0.
- Prescaler:
  - Counts 0..DIV-1, where DIV = test ? TEST_DIV : TICK_DIV.
  - tick_seg=1 for the single cycle in which the count = DIV-1, then wraps to 0.
  - Any change of test clears the prescaler on the next edge, with no tick in that cycle.
- Channel actions occur on the edge ending a tick_seg cycle; results are visible the following cycle.
- Per-channel FSM states: IDLE, HOLD, DONE.
  - IDLE:
    - Go to HOLD when entrada&activo=1 (any cycle); set hold_cnt=0 and freeze decay_cnt.
    - On a tick, if decay_cnt==DECAY_S-1: decay_cnt=0 and nivel decrements, saturating at 0. Otherwise decay_cnt+1.
  - HOLD:
    - If entrada&activo=0, go to IDLE; hold_cnt=0 and decay_cnt resumes from its frozen value.
    - Else, on a tick, hold_cnt+1. When hold_cnt==HOLD_S-1 on a tick:
      - nivel+1, saturating at max; senal_hold pulses even if already at max.
      - decay_cnt=0, go to DONE.
    - No decay is applied in HOLD.
  - DONE:
    - Decay runs exactly as in IDLE.
    - Go to IDLE when entrada=0. A new increment requires release and re-press.
- Simultaneous events:
  - If IDLE→HOLD entry coincides with a decay tick, the entry wins and no decrement occurs.
  - If entrada drops on the completing tick, the increment is still applied (completion has priority).
- critico is registered: it follows nivel==0 with nivel's own timing.
- Channels are fully independent; N_CH=1 and LVL_W=1 must work.
- Reset asserted mid-hold aborts the hold with no senal_hold pulse. All state returns to reset values.
- Counter widths are sized with $clog2 of their respective limits. No wrap occurs beyond those limits.

Optional Feature:
Macro ALARMA_MULTI_EN.
- Defined: alarma is registered high while two or more channels have critico=1, and low otherwise.
- Undefined: alarma is tied to 0 and the population-count logic is omitted.
- Ports are identical in both builds.

Test Plan:
Bench parameters for all scenarios: N_CH=4, LVL_W=2, TICK_DIV=10, TEST_DIV=2, DECAY_S=3, HOLD_S=2.
- Release reset, entrada=0 -> nivel=3 on all channels; every channel reaches 2 after 3 ticks (30 clk), 0 after 9 ticks, then stays 0; critico=1 from then on.
- Level 1, entrada[0]=1 with activo[0]=1 held -> after 2 ticks nivel0=2 and senal_hold[0] pulses once; keeping entrada high gives no further increment until released and re-pressed.
- Same stimulus with activo[0]=0 -> no HOLD, no senal_hold, decay continues.
- entrada[1] pulsed for 1 tick then released -> no increment; decay_cnt resumes from its frozen value, so the next decrement falls exactly one hold duration later than without the press.
- test=1 -> tick_seg period becomes 2 clk; toggling test mid-count gives no tick that cycle. reset=0 asserted mid-HOLD -> immediate nivel=3 and senal_hold=0.
- With ALARMA_MULTI_EN defined, drive channels 0 and 2 to 0 -> alarma=1; raise channel 2 to 1 -> alarma=0. Without the macro, alarma stays 0 throughout.
